// File: rtl/lza_norm_sequencer.sv
// rtl/lza_norm_sequencer.sv - LZA-guided multi-cycle mantissa normalizer
module lza_norm_sequencer #(
    parameter int WIDTH      = 27,
    parameter int EXP_W      = 8,
    parameter int SHIFT_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mant_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [WIDTH-1:0] lza_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mant_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             zero_out,
    output logic             underflow,
    output logic             corrected
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, ENCODE, SHIFT, CORRECT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mant_q, mant_d, lza_q, lza_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic             zero_q, zero_d, uf_q, uf_d, corr_q, corr_d;

    logic [CW-1:0]    lead, lz, s, k;
    logic [EXP_W-1:0] exp_m1;

    // Lowest-to-highest scan so the highest set LZA bit wins.
    always_comb begin
        lead = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lza_q[i]) lead = CW'(i);
        end
    end

    // Shift is capped at exp-1 so the exponent bottoms out at 1, never 0.
    always_comb begin
        lz     = CW'(WIDTH - 1) - lead;
        exp_m1 = exp_q - EXP_W'(1);
        if (exp_q == '0)
            s = '0;
        else if (exp_m1 < EXP_W'(lz))
            s = CW'(exp_m1);
        else
            s = lz;
        k = (rem_q > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        lza_d   = lza_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        zero_d  = zero_q;
        uf_d    = uf_q;
        corr_d  = corr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d  = mant_in;
                    exp_d   = exp_in;
                    lza_d   = lza_in;
                    rem_d   = '0;
                    zero_d  = 1'b0;
                    uf_d    = 1'b0;
                    corr_d  = 1'b0;
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                if (mant_q == '0 || lza_q == '0) begin
                    mant_d  = '0;
                    exp_d   = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    uf_d    = (s < lz);
                    rem_d   = s;
                    state_d = (s != '0) ? SHIFT : CORRECT;
                end
            end
            SHIFT: begin
                mant_d = mant_q << k;
                exp_d  = exp_q - EXP_W'(k);
                rem_d  = rem_q - k;
                if (rem_q == k) state_d = CORRECT;
            end
            CORRECT: begin
                if (!mant_q[WIDTH-1]) begin
                    if (mant_q != '0 && exp_q > EXP_W'(1)) begin
                        mant_d = mant_q << 1;
                        exp_d  = exp_q - EXP_W'(1);
                        corr_d = 1'b1;
                    end else if (exp_q <= EXP_W'(1)) begin
                        uf_d = 1'b1;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    zero_d  = 1'b0;
                    uf_d    = 1'b0;
                    corr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mant_q  <= '0;
            lza_q   <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
            corr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            lza_q   <= lza_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
            uf_q    <= uf_d;
            corr_q  <= corr_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mant_out  = mant_q;
    assign exp_out   = exp_q;
    assign zero_out  = zero_q;
    assign underflow = uf_q;
    assign corrected = corr_q;
endmodule

// File: tb/tb_lza_norm_sequencer.sv
// tb/tb_lza_norm_sequencer.sv - directed table plus randomized model check of lza_norm_sequencer
module tb_lza_norm_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [26:0] mant_in, mant_out, lza_in;
    logic [7:0]  exp_in, exp_out;
    logic        zero_out, underflow, corrected;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [26:0] m;
        logic [7:0]  e;
        logic [26:0] l;
        logic [26:0] xm;
        logic [7:0]  xe;
        logic        xz, xu, xc;
        int          lat;
    } vec_t;

    lza_norm_sequencer #(.WIDTH(27), .EXP_W(8), .SHIFT_STEP(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mant_in(mant_in), .exp_in(exp_in), .lza_in(lza_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mant_out(mant_out), .exp_out(exp_out),
        .zero_out(zero_out), .underflow(underflow), .corrected(corrected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Whole-shift reference: one shift by the full effective amount, then the correction rule.
    function automatic vec_t model(input logic [26:0] m, input logic [7:0] e, input logic [26:0] l);
        vec_t r;
        int hi, lz, s, ee;
        logic [26:0] mm;
        r.m = m; r.e = e; r.l = l;
        r.xz = 0; r.xu = 0; r.xc = 0;
        if (m == 0 || l == 0) begin
            r.xm = 0; r.xe = 0; r.xz = 1; r.lat = 1;
            return r;
        end
        hi = 0;
        for (int i = 26; i >= 0; i--) if (l[i]) begin hi = i; break; end
        lz = 26 - hi;
        s  = (e == 0) ? 0 : ((lz < int'(e) - 1) ? lz : int'(e) - 1);
        r.xu  = (s < lz);
        mm    = m << s;
        ee    = int'(e) - s;
        r.lat = 2 + (s + 7) / 8;
        if (!mm[26]) begin
            if (mm != 0 && ee > 1) begin
                mm = mm << 1; ee = ee - 1; r.xc = 1;
            end else if (ee <= 1) begin
                r.xu = 1;
            end
        end
        r.xm = mm; r.xe = 8'(ee);
        return r;
    endfunction

    task automatic run_op(input vec_t v, input int hold);
        int n;
        logic [37:0] snap;
        mant_in = v.m; exp_in = v.e; lza_in = v.l; in_valid = 1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("out_valid_seen", out_valid, 1);
        chk("latency", n, v.lat);
        chk("mant_out", mant_out, v.xm);
        chk("exp_out", exp_out, v.xe);
        chk("zero_out", zero_out, v.xz);
        chk("underflow", underflow, v.xu);
        chk("corrected", corrected, v.xc);
        snap = {mant_out, exp_out, zero_out, underflow, corrected};
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_stable", {mant_out, exp_out, zero_out, underflow, corrected}, snap);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_flags", {zero_out, underflow, corrected}, 0);
    endtask

    vec_t tbl[10];
    vec_t v;
    logic [26:0] one = 27'd1;
    logic [26:0] rm, rl;
    int p, q, re;

    initial begin
        //         m            e    l            xm           xe   z  u  c  lat
        tbl[0] = '{27'h0400000, 100, 27'h0400000, 27'h4000000, 96,  0, 0, 0, 3};
        tbl[1] = '{27'h0400000, 100, 27'h0800000, 27'h4000000, 96,  0, 0, 1, 3};
        tbl[2] = '{27'h0000040, 50,  27'h0000040, 27'h4000000, 30,  0, 0, 0, 5};
        tbl[3] = '{27'h0010000, 5,   27'h0010000, 27'h0100000, 1,   0, 1, 0, 3};
        tbl[4] = '{27'h0000000, 77,  27'h0000123, 27'h0000000, 0,   1, 0, 0, 1};
        tbl[5] = '{27'h4000001, 10,  27'h4000000, 27'h4000001, 10,  0, 0, 0, 2};
        tbl[6] = '{27'h0000400, 0,   27'h0000400, 27'h0000400, 0,   0, 1, 0, 2};
        tbl[7] = '{27'h0000055, 9,   27'h0000000, 27'h0000000, 0,   1, 0, 0, 1};
        tbl[8] = '{27'h0000300, 200, 27'h00002FF, 27'h6000000, 183, 0, 0, 0, 5};
        tbl[9] = '{27'h0010000, 11,  27'h0010000, 27'h4000000, 1,   0, 0, 0, 4};

        rst = 1; in_valid = 0; out_ready = 0;
        mant_in = 0; exp_in = 0; lza_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", {mant_out, exp_out, zero_out, underflow, corrected}, 0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_op(tbl[i], i % 3);

        // Zero result under backpressure while a second operand is already offered.
        mant_in = 0; exp_in = 77; lza_in = 27'h5; in_valid = 1;
        @(posedge clk); #1;
        mant_in = tbl[0].m; exp_in = tbl[0].e; lza_in = tbl[0].l;
        @(posedge clk); #1;
        chk("bp_zero_latency", out_valid, 1);
        chk("bp_zero_flag", zero_out, 1);
        chk("bp_zero_exp", exp_out, 0);
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_zero", {zero_out, mant_out, exp_out}, {1'b1, 35'd0});
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("bp_after_valid", out_valid, 0);
        chk("bp_after_in_ready", in_ready, 1);
        run_op(tbl[0], 0);

        // Reset during the second SHIFT cycle of the multi-step case.
        mant_in = tbl[2].m; exp_in = tbl[2].e; lza_in = tbl[2].l; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_outputs", {mant_out, exp_out, zero_out, underflow, corrected}, 0);
        @(posedge clk); #1;
        rst = 0;
        run_op(tbl[2], 1);

        for (int n = 0; n < 150; n++) begin
            p  = $urandom_range(0, 26);
            rm = (one << p) | (27'($urandom) & ((one << p) - 1));
            if ($urandom_range(0, 19) == 0) rm = 0;
            case ($urandom_range(0, 2))
                0:       q = p;
                1:       q = (p < 26) ? p + 1 : 26;
                default: q = $urandom_range(0, 26);
            endcase
            rl = (one << q) | (27'($urandom) & ((one << q) - 1));
            if ($urandom_range(0, 29) == 0) rl = 0;
            re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 255);
            v  = model(rm, 8'(re), rl);
            run_op(v, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
